// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the memory stage.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Big-endian: byte at offset k sits on lane 3-k; be[3] covers bits 31:24.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b1000 >> off;
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational big-endian lane extraction and zero/sign extension of load data.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    unique case (offset)
      2'd0: byte_v = rdata[31:24];
      2'd1: byte_v = rdata[23:16];
      2'd2: byte_v = rdata[15:8];
      2'd3: byte_v = rdata[7:0];
    endcase
    half_v = offset[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      SZ_BYTE: result = {{24{is_signed & byte_v[7]}}, byte_v};
      SZ_HALF: result = {{16{is_signed & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory stage: ready/valid data-memory access with pipeline stall and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              exc_misalign
);

  state_e      state;
  logic        memop;
  logic        misalign;
  logic [1:0]  off;
  logic [4:0]  l_rd;
  logic [1:0]  l_size;
  logic        l_signed;
  logic        l_reg_write;
  logic        l_store;
  logic [1:0]  l_off;
  logic [31:0] load_val;

  assign memop = in_mem_read | in_mem_write;
  assign off   = in_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = in_valid & memop &
                    (((in_size == SZ_HALF) & off[0]) | (in_size[1] & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign stall = ~reset & ((state == StIdle) ? (in_valid & memop & ~misalign) : ~bus_ready);

  mem_load_align u_load_align (
    .rdata     (bus_rdata),
    .offset    (l_off),
    .size      (l_size),
    .is_signed (l_signed),
    .result    (load_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= 4'h0;
      bus_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      exc_misalign <= 1'b0;
      l_rd         <= 5'd0;
      l_size       <= SZ_BYTE;
      l_signed     <= 1'b0;
      l_reg_write  <= 1'b0;
      l_store      <= 1'b0;
      l_off        <= 2'b00;
    end else begin
      exc_misalign <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid && memop && !misalign) begin
            bus_req     <= 1'b1;
            bus_we      <= in_mem_write;
            bus_addr    <= {in_alu_result[ADDR_W-1:2], 2'b00};
            bus_be      <= lane_be(in_size, off);
            bus_wdata   <= lane_wdata(in_size, in_store_data);
            l_rd        <= in_rd;
            l_size      <= in_size;
            l_signed    <= in_signed;
            l_reg_write <= in_reg_write;
            l_store     <= in_mem_write;
            l_off       <= off;
            wb_valid    <= 1'b0;
            state       <= StBusy;
          end else begin
            // Pass-through slot; a trapped access retires here with write-back suppressed.
            wb_valid     <= in_valid;
            wb_data      <= in_alu_result;
            wb_rd        <= in_rd;
            wb_reg_write <= in_reg_write & ~misalign;
            exc_misalign <= misalign;
          end
        end
        StBusy: begin
          wb_valid <= 1'b0;
          if (bus_ready) begin
            bus_req      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_data      <= load_val;
            wb_rd        <= l_rd;
            wb_reg_write <= l_reg_write & ~l_store;
            state        <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; honours MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_mem_read, in_mem_write, in_signed, in_reg_write;
  logic [1:0]  in_size;
  logic [31:0] in_alu_result, in_store_data;
  logic [4:0]  in_rd;
  logic        stall, bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        wb_valid, wb_reg_write, exc_misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  logic        obs_req, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  int          obs_stalls;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_size       (in_size),
    .in_signed     (in_signed),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .stall         (stall),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_ready     (bus_ready),
    .bus_rdata     (bus_rdata),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .exc_misalign  (exc_misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one memory op, hold bus_ready low for 'waits' BUSY cycles, then respond.
  task automatic mem_op(input logic wr, input logic rd_en, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic [4:0] rd);
    int stalls = 0;
    in_valid = 1'b1; in_mem_read = rd_en; in_mem_write = wr; in_size = sz; in_signed = sgn;
    in_alu_result = addr; in_store_data = wdata; in_rd = rd; in_reg_write = 1'b1;
    #1;
    if (stall) stalls++;
    tick();
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    obs_req = bus_req; obs_we = bus_we; obs_addr = bus_addr; obs_be = bus_be;
    obs_wdata = bus_wdata;
    for (int i = 0; i < waits; i++) begin
      bus_ready = 1'b0;
      #1;
      if (stall) stalls++;
      check("hold_req", {31'd0, bus_req}, 32'd1);
      tick();
    end
    bus_ready = 1'b1; bus_rdata = rdata;
    #1;
    if (stall) stalls++;
    tick();
    bus_ready = 1'b0; bus_rdata = 32'h0;
    obs_stalls = stalls;
  endtask

  initial begin
    reset = 1'b1; bus_ready = 1'b0; bus_rdata = 32'h0;
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_size = 2'b10;
    in_signed = 1'b0; in_alu_result = 32'h40; in_store_data = 32'h0; in_rd = 5'd1;
    in_reg_write = 1'b1;
    repeat (2) tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_exc", {31'd0, exc_misalign}, 32'd0);

    in_valid = 1'b0; in_mem_read = 1'b0;
    reset = 1'b0;
    tick();

    // ALU pass-through
    in_valid = 1'b1; in_alu_result = 32'h1234; in_rd = 5'd5; in_reg_write = 1'b1;
    #1;
    check("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("alu_wb_data", wb_data, 32'h1234);
    check("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("alu_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    tick();
    check("idle_wb_valid", {31'd0, wb_valid}, 32'd0);

    // sw with two wait states
    mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 2, 32'h0, 5'd0);
    check("sw_req", {31'd0, obs_req}, 32'd1);
    check("sw_we", {31'd0, obs_we}, 32'd1);
    check("sw_addr", obs_addr, 32'h100);
    check("sw_be", {28'd0, obs_be}, 32'hF);
    check("sw_wdata", obs_wdata, 32'hDEADBEEF);
    check("sw_stalls", obs_stalls, 32'd3);
    check("sw_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("sw_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    check("sw_req_done", {31'd0, bus_req}, 32'd0);

    // sb 0xAB at 0x103
    mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h000000AB, 0, 32'h0, 5'd0);
    check("sb_be", {28'd0, obs_be}, 32'h1);
    check("sb_wdata", obs_wdata, 32'hABABABAB);
    check("sb_addr", obs_addr, 32'h100);

    // sh at 0x102
    mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, 1, 32'h0, 5'd0);
    check("sh_be", {28'd0, obs_be}, 32'h3);
    check("sh_wdata", obs_wdata, 32'hBEEFBEEF);

    // lb signed at 0x101
    mem_op(1'b0, 1'b1, 2'b00, 1'b1, 32'h101, 32'h0, 0, 32'h11F02233, 5'd9);
    check("lb_we", {31'd0, obs_we}, 32'd0);
    check("lb_be", {28'd0, obs_be}, 32'h4);
    check("lb_stalls", obs_stalls, 32'd1);
    check("lb_data", wb_data, 32'hFFFFFFF0);
    check("lb_rd", {27'd0, wb_rd}, 32'd9);
    check("lb_rw", {31'd0, wb_reg_write}, 32'd1);

    mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0, 0, 32'h11F02233, 5'd9);
    check("lbu_data", wb_data, 32'h000000F0);

    mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0, 1, 32'h11F02233, 5'd10);
    check("lhu_data", wb_data, 32'h00002233);

    mem_op(1'b0, 1'b1, 2'b01, 1'b1, 32'h100, 32'h0, 0, 32'h80011234, 5'd11);
    check("lh_data", wb_data, 32'hFFFF8001);

    // read+write both set behaves as store
    mem_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'h55AA55AA, 0, 32'h0, 5'd3);
    check("rw_we", {31'd0, obs_we}, 32'd1);
    check("rw_wb_rw", {31'd0, wb_reg_write}, 32'd0);

    // reset while BUSY aborts the access
    in_valid = 1'b1; in_mem_read = 1'b1; in_size = 2'b10; in_alu_result = 32'h300;
    tick();
    in_valid = 1'b0; in_mem_read = 1'b0;
    check("rb_req_busy", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("rb_stall_rst", {31'd0, stall}, 32'd0);
    tick();
    check("rb_req", {31'd0, bus_req}, 32'd0);
    check("rb_wb_valid", {31'd0, wb_valid}, 32'd0);
    reset = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    check("rb_idle_stall", {31'd0, stall}, 32'd0);
    tick();
    bus_ready = 1'b0; bus_rdata = 32'h0;
    check("rb_discard", {31'd0, wb_valid}, 32'd0);

    // misaligned lw at 0x102
`ifdef MEM_MISALIGN_TRAP_EN
    in_valid = 1'b1; in_mem_read = 1'b1; in_size = 2'b10; in_alu_result = 32'h102;
    in_rd = 5'd7; in_reg_write = 1'b1;
    #1;
    check("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    in_valid = 1'b0; in_mem_read = 1'b0;
    check("mis_req", {31'd0, bus_req}, 32'd0);
    check("mis_exc", {31'd0, exc_misalign}, 32'd1);
    check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("mis_wb_rw", {31'd0, wb_reg_write}, 32'd0);
    tick();
    check("mis_exc_clr", {31'd0, exc_misalign}, 32'd0);
`else
    mem_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 1, 32'h11F02233, 5'd7);
    check("mis_req", {31'd0, obs_req}, 32'd1);
    check("mis_addr", obs_addr, 32'h100);
    check("mis_be", {28'd0, obs_be}, 32'hF);
    check("mis_data", wb_data, 32'h11F02233);
    check("mis_exc", {31'd0, exc_misalign}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
